byte_unstriping: RTL and testbench
==================================

Name: byte_unstriping

Overview:
- Receive-side counterpart of the two-lane byte striper in the phy path.
- Takes two lane byte streams, each updated at half rate, and re-merges them into one byte stream at clk_2f.
- Output order is lane 0 byte first, then lane 1 byte.
- Aligns itself to lane 0's first valid word, drops back to idle after a run of empty words, and flags lane-order violations.

Parameters:
- DW, 8, lane and output byte width.
- IDLE_WORDS, 4, consecutive empty lane words (both valids 0) that return the block to IDLE; legal range 1..7.
- CW, 3, idle counter width; must satisfy 2^CW > IDLE_WORDS.

Ports:
- clk_2f  input  1  double-rate clock.
- reset  input  1  synchronous, active-low.
- lane_0_cond  input  DW  lane 0 byte; held stable 2 clk_2f cycles per word.
- valid_0_cond  input  1  lane 0 valid; same timing as lane_0_cond.
- lane_1_cond  input  DW  lane 1 byte; changes on the same edges as lane 0.
- valid_1_cond  input  1  lane 1 valid.
- data_out  output  DW  merged byte stream, registered.
- valid_out  output  1  data_out valid, registered.
- active  output  1  high while aligned (ACTIVE state), registered.
- err_order  output  1  one-cycle pulse on a lane-order violation, registered.

Behaviour:
- Interface decision: reset is synchronous, active-low; clock is clk_2f. All state updates on posedge clk_2f.
- Reset (reset==0 at an edge):
  - State goes to IDLE; sel=0; idle counter=0; hold byte and hold valid=0.
  - data_out=0, valid_out=0, active=0, err_order=0.
  - Reset mid-word discards the held lane 1 byte; it is never emitted.
- Internal registers: state {IDLE, ACTIVE}; phase bit sel; hold1[DW-1:0]; hv1; idle counter.
- err_order defaults to 0 every edge unless set below.
- IDLE, each edge:
  - data_out<=0, valid_out<=0.
  - If valid_0_cond==1, this edge is the capture (phase-0) edge:
    - data_out<=lane_0_cond, valid_out<=1.
    - hold1<=lane_1_cond, hv1<=valid_1_cond.
    - sel<=1, state<=ACTIVE, active<=1, idle counter<=0.
  - If valid_0_cond==0 and valid_1_cond==1: err_order<=1; stay in IDLE.
- ACTIVE, sel==1 edge (lane 1 slot):
  - data_out<=hold1, valid_out<=hv1, sel<=0.
  - Lane inputs are ignored on this edge.
- ACTIVE, sel==0 edge (capture):
  - data_out<=lane_0_cond, hold1<=lane_1_cond, sel<=1.
  - v0=valid_0_cond, v1=valid_1_cond.
  - Order error (v0==0 && v1==1): err_order<=1, valid_out<=0, hv1<=0 (whole word dropped), idle counter<=0.
  - Otherwise: valid_out<=v0, hv1<=v1.
  - If v0==0 && v1==0:
    - If counter==IDLE_WORDS-1: state<=IDLE, active<=0, sel<=0, counter<=0.
    - Else counter increments.
  - Any valid bit set: counter<=0.
- Latency: a word presented at capture edge E gives the lane 0 byte on the outputs after E and the lane 1 byte after E+1. Throughput is 1 byte per clk_2f cycle.
- Partial word (v0=1, v1=0): lane 0 byte is valid, lane 1 slot has valid_out=0; block stays ACTIVE.
- On entering IDLE from a capture edge: the following (would-be lane 1) cycle outputs data_out=0, valid_out=0. The next valid_0_cond re-aligns on any edge parity.
- data_out carries the raw byte even when valid_out=0 in ACTIVE; it is forced to 0 only in IDLE and reset.

Test Plan:
- Reset: hold reset=0 3 cycles with lanes=0xFF, valids=1 -> data_out=0, valid_out=0, active=0, err_order=0 throughout.
- Stream: after reset release, words (0xA1,0xB2) then (0xC3,0xD4), each held 2 cycles with both valids=1 starting at edge E -> data_out A1,B2,C3,D4 on the outputs after E..E+3; valid_out=1 each cycle; active=1 from after E.
- Partial word: ACTIVE, word (0x11 valid, 0x22 invalid) -> 0x11 with valid_out=1, then valid_out=0; active stays 1; counter cleared.
- Idle exit (IDLE_WORDS=4): 4 empty words after the stream -> active falls after the 4th empty capture edge, then data_out=0; a later word (0x55,0x66) re-aligns on an odd cycle and outputs 0x55,0x66.
- Order error: ACTIVE, word valid_0=0, valid_1=1, lane_1=0x77 -> err_order=1 for exactly one cycle; valid_out=0 in both slots; 0x77 is never valid; counter reset.
- Reset mid-word: reset=0 at the sel==1 edge after capturing (0x99,0xAA) -> 0xAA never emitted; outputs 0; after release, realigns on the next valid_0_cond.

Source files
------------

// File: rtl/byte_unstriping.sv
// byte_unstriping: the receive-side merge for the two-lane byte striper.
// Two half-rate lane streams are folded back into one byte stream at clk_2f.
// The lane 0 byte comes first and the lane 1 byte follows. The block aligns to
// the first valid lane 0 word. It returns to idle after IDLE_WORDS consecutive
// empty words and pulses err_order when lane 1 is valid without lane 0.
// IDLE_WORDS must lie in 1..7, and 2**CW must exceed IDLE_WORDS.
module byte_unstriping #(
  parameter int DW         = 8,
  parameter int IDLE_WORDS = 4,
  parameter int CW         = 3
) (
  input  logic          clk_2f,
  input  logic          reset,
  input  logic [DW-1:0] lane_0_cond,
  input  logic          valid_0_cond,
  input  logic [DW-1:0] lane_1_cond,
  input  logic          valid_1_cond,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          active,
  output logic          err_order
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [CW-1:0] LP_LAST_IDLE = CW'(IDLE_WORDS - 1);

  state_t        r_state;
  state_t        w_stateNext;

  logic          r_sel;
  logic          w_selNext;
  logic [DW-1:0] r_hold1;
  logic [DW-1:0] w_hold1Next;
  logic          r_hv1;
  logic          w_hv1Next;
  logic [CW-1:0] r_idleCnt;
  logic [CW-1:0] w_idleCntNext;

  logic [DW-1:0] r_dataOut;
  logic          r_validOut;
  logic          r_active;
  logic          r_errOrder;
  logic [DW-1:0] w_dataNext;
  logic          w_validNext;
  logic          w_activeNext;
  logic          w_errNext;

  logic          w_emptyWord;
  logic          w_orderErr;
  logic          w_idleDone;

  assign w_emptyWord = !valid_0_cond && !valid_1_cond;
  assign w_orderErr  = !valid_0_cond &&  valid_1_cond;
  assign w_idleDone  = (r_idleCnt == LP_LAST_IDLE);

  assign data_out  = r_dataOut;
  assign valid_out = r_validOut;
  assign active    = r_active;
  assign err_order = r_errOrder;

  // State register: alignment state, with a synchronous active-low clear.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: align on valid lane 0, and drop out after the final empty capture.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (valid_0_cond) begin
          w_stateNext = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (!r_sel && w_emptyWord && w_idleDone) begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Output/datapath decode: pick the byte for this slot and update the held lane 1 byte.
  always_comb begin
    w_selNext     = r_sel;
    w_hold1Next   = r_hold1;
    w_hv1Next     = r_hv1;
    w_idleCntNext = r_idleCnt;
    w_dataNext    = '0;
    w_validNext   = 1'b0;
    w_errNext     = 1'b0;
    w_activeNext  = (w_stateNext == S_ACTIVE);
    case (r_state)
      S_IDLE: begin
        if (valid_0_cond) begin
          w_dataNext    = lane_0_cond;
          w_validNext   = 1'b1;
          w_hold1Next   = lane_1_cond;
          w_hv1Next     = valid_1_cond;
          w_selNext     = 1'b1;
          w_idleCntNext = '0;
        end else if (valid_1_cond) begin
          w_errNext = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (r_sel) begin
          w_dataNext  = r_hold1;
          w_validNext = r_hv1;
          w_selNext   = 1'b0;
        end else begin
          w_dataNext  = lane_0_cond;
          w_hold1Next = lane_1_cond;
          w_selNext   = 1'b1;
          if (w_orderErr) begin
            w_errNext     = 1'b1;
            w_validNext   = 1'b0;
            w_hv1Next     = 1'b0;
            w_idleCntNext = '0;
          end else begin
            w_validNext = valid_0_cond;
            w_hv1Next   = valid_1_cond;
            if (w_emptyWord) begin
              if (w_idleDone) begin
                w_selNext     = 1'b0;
                w_idleCntNext = '0;
              end else begin
                w_idleCntNext = r_idleCnt + CW'(1);
              end
            end else begin
              w_idleCntNext = '0;
            end
          end
        end
      end
      default: begin
        w_selNext     = 1'b0;
        w_idleCntNext = '0;
      end
    endcase
  end

  // Datapath and output registers: a reset discards any half-emitted word.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      r_sel      <= 1'b0;
      r_hold1    <= '0;
      r_hv1      <= 1'b0;
      r_idleCnt  <= '0;
      r_dataOut  <= '0;
      r_validOut <= 1'b0;
      r_active   <= 1'b0;
      r_errOrder <= 1'b0;
    end else begin
      r_sel      <= w_selNext;
      r_hold1    <= w_hold1Next;
      r_hv1      <= w_hv1Next;
      r_idleCnt  <= w_idleCntNext;
      r_dataOut  <= w_dataNext;
      r_validOut <= w_validNext;
      r_active   <= w_activeNext;
      r_errOrder <= w_errNext;
    end
  end

endmodule

// File: tb/tb_byte_unstriping.sv
// Testbench for byte_unstriping: directed per-cycle vectors, each paired with a
// hand-computed expected output record that a separate monitor pops after every edge.
module tb_byte_unstriping;

  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          valid;
    logic          act;
    logic          err;
    logic [15:0]   idx;
  } exp_t;

  logic          clk_2f;
  logic          reset;
  logic [DW-1:0] lane_0_cond;
  logic          valid_0_cond;
  logic [DW-1:0] lane_1_cond;
  logic          valid_1_cond;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          active;
  logic          err_order;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycleIdx   = 0;

  byte_unstriping #(.DW(DW), .IDLE_WORDS(4), .CW(3)) dut (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .lane_0_cond (lane_0_cond),
    .valid_0_cond(valid_0_cond),
    .lane_1_cond (lane_1_cond),
    .valid_1_cond(valid_1_cond),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active      (active),
    .err_order   (err_order)
  );

  // Free-running double-rate clock.
  initial begin
    clk_2f = 1'b0;
    forever #5 clk_2f = ~clk_2f;
  end

  // Compare one expected record against the outputs that follow its edge.
  task automatic checkOutput(input exp_t e);
    checkCount++;
    if (data_out === e.data) passCount++;
    else $display("[TB] FAIL data cyc=%0d got=%h exp=%h", e.idx, data_out, e.data);
    checkCount++;
    if (valid_out === e.valid) passCount++;
    else $display("[TB] FAIL valid_out cyc=%0d got=%b exp=%b", e.idx, valid_out, e.valid);
    checkCount++;
    if (active === e.act) passCount++;
    else $display("[TB] FAIL active cyc=%0d got=%b exp=%b", e.idx, active, e.act);
    checkCount++;
    if (err_order === e.err) passCount++;
    else $display("[TB] FAIL err_order cyc=%0d got=%b exp=%b", e.idx, err_order, e.err);
  endtask

  // Drive one cycle of inputs before the next edge and queue what must follow that edge.
  task automatic applyStimulus(input logic rst, input logic [DW-1:0] l0, input logic v0,
                               input logic [DW-1:0] l1, input logic v1,
                               input logic [DW-1:0] eData, input logic eValid,
                               input logic eAct, input logic eErr);
    exp_t e;
    @(negedge clk_2f);
    reset        = rst;
    lane_0_cond  = l0;
    valid_0_cond = v0;
    lane_1_cond  = l1;
    valid_1_cond = v1;
    e.data  = eData;
    e.valid = eValid;
    e.act   = eAct;
    e.err   = eErr;
    e.idx   = 16'(cycleIdx);
    expQ.push_back(e);
    cycleIdx++;
  endtask

  // An empty word seen while aligned: the raw bytes appear with valid_out low.
  task automatic emptyWordActive();
    applyStimulus(1'b1, 8'h5A, 1'b0, 8'hA5, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: after each edge, pop the matching expectation and check it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_2f);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checkCount);
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence.
  initial begin
    reset        = 1'b0;
    lane_0_cond  = '0;
    valid_0_cond = 1'b0;
    lane_1_cond  = '0;
    valid_1_cond = 1'b0;

    // Reset held with busy lanes: everything stays quiet.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Two full words.
    applyStimulus(1'b1, 8'hA1, 1'b1, 8'hB2, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hA1, 1'b1, 8'hB2, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b1, 8'hD4, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b1, 8'hD4, 1'b1, 8'hD4, 1'b1, 1'b1, 1'b0);

    // Two empty words, then a partial word that must clear the idle count.
    emptyWordActive();
    emptyWordActive();
    applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0);

    // Two more empty words, then an order error that must also clear the count.
    emptyWordActive();
    emptyWordActive();
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h77, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h77, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0);

    // Four empty words: active falls after the fourth capture, and the next slot is zeroed.
    emptyWordActive();
    emptyWordActive();
    emptyWordActive();
    applyStimulus(1'b1, 8'h5A, 1'b0, 8'hA5, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Lane 1 without lane 0 while idle.
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h33, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

    // Realign on the opposite edge parity.
    applyStimulus(1'b1, 8'h55, 1'b1, 8'h66, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b1, 8'h66, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0);

    // Reset in the lane 1 slot: 0xAA is discarded.
    applyStimulus(1'b1, 8'h99, 1'b1, 8'hAA, 1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h99, 1'b1, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h99, 1'b1, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h12, 1'b1, 8'h34, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h12, 1'b1, 8'h34, 1'b1, 8'h34, 1'b1, 1'b1, 1'b0);

    @(posedge clk_2f);
    #3;
    checkCount++;
    if (expQ.size() == 0) passCount++;
    else $display("[TB] FAIL drain got=%0d exp=0", expQ.size());

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
